// File: rtl/result_serializer.sv
// Captures a packed vector of compressor column outputs on start and shifts it out
// LSB-first over a 1-bit valid/ready stream. Optional MISR signature under `RESULT_MISR_EN`.
module result_serializer #(
  parameter int              NDST = 17,
  parameter int              CNTW = 16,
  parameter logic [NDST-1:0] POLY = 17'h1_2001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NDST-1:0] dst,
  input  logic            start,
  input  logic            clr,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            out_bit,
  output logic            out_last,
  output logic            busy,
  output logic            overrun,
  output logic [CNTW-1:0] capture_cnt
`ifdef RESULT_MISR_EN
  ,
  output logic [NDST-1:0] sig
`endif
);

  localparam int IDXW = (NDST > 2) ? $clog2(NDST) : 1;

  // busy mirrors the FSM state: it is high exactly while in SHIFT.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [NDST-1:0] shreg;
  logic [IDXW-1:0] idx;

  // Stream handshake: a bit moves when out_valid && out_ready at posedge clk;
  // out_bit and out_last hold steady while out_valid && !out_ready.
  logic beat;
  logic last_beat;
  logic accept;

  assign beat      = out_valid && out_ready;
  assign last_beat = beat && (idx == IDXW'(NDST - 1));
  assign accept    = start && ((state == IDLE) || last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_bit     <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      capture_cnt <= '0;
    end else begin
      if (accept) begin
        state     <= SHIFT;
        shreg     <= dst;
        idx       <= '0;
        out_valid <= 1'b1;
        out_bit   <= dst[0];
        out_last  <= 1'b0;
        busy      <= 1'b1;
      end else if (last_beat) begin
        state     <= IDLE;
        shreg     <= shreg >> 1;
        idx       <= '0;
        out_valid <= 1'b0;
        out_bit   <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else if (state == SHIFT && beat) begin
        shreg    <= shreg >> 1;
        idx      <= idx + 1'b1;
        out_bit  <= shreg[1];
        out_last <= (idx == IDXW'(NDST - 2));
      end

      // clr takes priority over a coincident overrun event.
      if (clr) begin
        overrun     <= 1'b0;
        capture_cnt <= accept ? CNTW'(1) : '0;
      end else begin
        if (start && !accept) overrun <= 1'b1;
        if (accept) capture_cnt <= capture_cnt + 1'b1;
      end
    end
  end

`ifdef RESULT_MISR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (accept) begin
      sig <= {sig[NDST-2:0], 1'b0} ^ (sig[NDST-1] ? POLY : '0) ^ dst;
    end
  end
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus random traffic, checked against a
// queue-based frame model. A second instance with CNTW=4 observes capture counter wrap.
module tb_result_serializer;

  localparam int              NDST = 17;
  localparam int              CNTW = 16;
  localparam logic [NDST-1:0] POLY = 17'h1_2001;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NDST-1:0] dst = '0;
  logic            start = 1'b0;
  logic            clr = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid, out_bit, out_last, busy, overrun;
  logic [CNTW-1:0] capture_cnt;
  logic            out_valid4, out_bit4, out_last4, busy4, overrun4;
  logic [3:0]      capture_cnt4;
`ifdef RESULT_MISR_EN
  logic [NDST-1:0] sig, sig4;
`endif

  result_serializer #(.NDST(NDST), .CNTW(CNTW), .POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .dst(dst), .start(start), .clr(clr),
    .out_ready(out_ready), .out_valid(out_valid), .out_bit(out_bit),
    .out_last(out_last), .busy(busy), .overrun(overrun),
    .capture_cnt(capture_cnt)
`ifdef RESULT_MISR_EN
    , .sig(sig)
`endif
  );

  result_serializer #(.NDST(NDST), .CNTW(4), .POLY(POLY)) dut4 (
    .clk(clk), .rst_n(rst_n), .dst(dst), .start(start), .clr(clr),
    .out_ready(out_ready), .out_valid(out_valid4), .out_bit(out_bit4),
    .out_last(out_last4), .busy(busy4), .overrun(overrun4),
    .capture_cnt(capture_cnt4)
`ifdef RESULT_MISR_EN
    , .sig(sig4)
`endif
  );

  // reference model: queue of bits still owed on the wire
  logic            exp_q[$];
  logic [CNTW-1:0] m_cnt;
  logic [3:0]      m_cnt4;
  logic            m_ovr;
  logic [NDST-1:0] m_sig;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = '0;
    m_cnt4 = '0;
    m_ovr  = 1'b0;
    m_sig  = '0;
  endtask

  // Called at negedge with inputs already set: check outputs, advance model, advance one cycle.
  task automatic step();
    logic exp_valid, beat, acc;
    int   rem;
    rem       = exp_q.size();
    exp_valid = (rem > 0);
    check("capture_cnt", 32'(capture_cnt), 32'(m_cnt));
    check("capture_cnt4", 32'(capture_cnt4), 32'(m_cnt4));
    check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef RESULT_MISR_EN
    check("sig", 32'(sig), 32'(m_sig));
`endif
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(exp_valid));
    if (exp_valid) begin
      check("out_bit", 32'(out_bit), 32'(exp_q[0]));
      check("out_last", 32'(out_last), 32'(rem == 1));
    end else begin
      check("out_last_idle", 32'(out_last), 32'(1'b0));
    end
    beat = exp_valid && out_ready;
    acc  = start && (rem == 0 || (rem == 1 && beat));
    if (beat) void'(exp_q.pop_front());
    if (acc) begin
      for (int i = 0; i < NDST; i++) exp_q.push_back(dst[i]);
      m_sig = (m_sig << 1) ^ (m_sig[NDST-1] ? POLY : '0) ^ dst;
    end
    if (clr) begin
      m_ovr  = 1'b0;
      m_cnt  = CNTW'(acc);
      m_cnt4 = 4'(acc);
    end else begin
      if (start && !acc) m_ovr = 1'b1;
      m_cnt  = m_cnt + CNTW'(acc);
      m_cnt4 = m_cnt4 + 4'(acc);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: one capture request cycle
  task automatic capture(input logic [NDST-1:0] d);
    dst   = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && b < 400) begin
      step();
      b++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    int i;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    rst_n = 1'b1;
    step();

    // single frame, sink always ready
    out_ready = 1'b1;
    capture(17'h1_0001);
    drain();
    step();

    // backpressure pattern 1,0,0 repeating
    capture(17'h0_AAAA);
    i = 0;
    while (exp_q.size() > 0 && i < 200) begin
      out_ready = (i % 3 == 0);
      step();
      i++;
    end
    drain();

    // back-to-back capture on the last beat, then a mid-frame start, then clr
    capture(NDST'($urandom));
    i = 0;
    while (exp_q.size() > 1 && i < 100) begin
      step();
      i++;
    end
    capture(17'h1_FFFF);
    while (exp_q.size() > NDST - 4 && i < 200) begin
      step();
      i++;
    end
    capture(17'h0_0000);
    step();
    check("overrun_set", 32'(overrun), 32'(1'b1));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'(1'b0));
    check("cnt_clr", 32'(capture_cnt), 32'(0));
    drain();

    // 16 captures wrap the 4-bit counter back to zero
    repeat (16) begin
      capture(NDST'($urandom));
      drain();
    end
    check("cnt4_wrap", 32'(capture_cnt4), 32'(0));
    check("cnt_16", 32'(capture_cnt), 32'(16));

    // reset mid-frame aborts immediately
    capture(NDST'($urandom));
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(1'b0));
    check("arst_out_bit", 32'(out_bit), 32'(1'b0));
    check("arst_out_last", 32'(out_last), 32'(1'b0));
    check("arst_busy", 32'(busy), 32'(1'b0));
    check("arst_overrun", 32'(overrun), 32'(1'b0));
    check("arst_cnt", 32'(capture_cnt), 32'(0));
`ifdef RESULT_MISR_EN
    check("arst_sig", 32'(sig), 32'(0));
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifdef RESULT_MISR_EN
    capture(17'h0_0001);
    check("misr_first", 32'(sig), 32'(1));
    drain();
    capture(17'h0_0002);
    check("misr_second", 32'(sig), 32'(0));
    drain();
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      dst       = NDST'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      step();
    end
    start = 1'b0;
    clr   = 1'b0;
    drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
